// File: rtl/ac97_pkg.sv
`timescale 1ns/1ps
// Shared AC97 link constants, codec register map and deframer state encoding.
package ac97_pkg;

    localparam int FRAME_LEN = 256;
    localparam int TAG_W     = 16;
    localparam int SLOT_W    = 20;

    localparam int TAG_FRAME_VALID = 15;
    localparam int TAG_SLOT1_VALID = 14;
    localparam int TAG_SLOT2_VALID = 13;
    localparam int TAG_SLOT3_VALID = 12;
    localparam int TAG_SLOT4_VALID = 11;

    localparam int SLOT1_START  = 16;
    localparam int SLOT2_START  = 36;
    localparam int SLOT3_START  = 56;
    localparam int SLOT4_START  = 76;
    localparam int DEFRAME_BITS = SLOT4_START + SLOT_W;
    // The response frame only ever carries tag, slot 1 and slot 2.
    localparam int RESP_BITS    = SLOT3_START;

    localparam logic [6:0] REG_RESET       = 7'h00;
    localparam logic [6:0] REG_MASTER_VOL  = 7'h02;
    localparam logic [6:0] REG_HP_VOL      = 7'h04;
    localparam logic [6:0] REG_PCM_OUT_VOL = 7'h18;
    localparam logic [6:0] REG_VENDOR_ID1  = 7'h7C;
    localparam logic [6:0] REG_VENDOR_ID2  = 7'h7E;

    localparam logic [15:0] RST_VOLUME     = 16'h8000;
    localparam logic [15:0] RST_VENDOR_ID1 = 16'h4144;
    localparam logic [15:0] RST_VENDOR_ID2 = 16'h5370;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_END  = 2'd2
    } deframe_state_t;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [SLOT_W-1:0] s1;
        logic [SLOT_W-1:0] s2;
        logic [SLOT_W-1:0] s3;
        logic [SLOT_W-1:0] s4;
    } rx_frame_t;

    function automatic logic [15:0] reg_reset_value(input logic [5:0] idx);
        logic [15:0] v;
        v = 16'h0000;
        case ({idx, 1'b0})
            REG_MASTER_VOL, REG_HP_VOL, REG_PCM_OUT_VOL: v = RST_VOLUME;
            REG_VENDOR_ID1: v = RST_VENDOR_ID1;
            REG_VENDOR_ID2: v = RST_VENDOR_ID2;
            default:        v = 16'h0000;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/ac97_codec_slave_if.sv
`timescale 1ns/1ps
// AC-link serial signals. The codec (slave) owns bit_clk and sdata_in; the
// controller (master) drives sync and sdata_out on bit_clk rising edges.
interface ac97_codec_slave_if;
    logic bit_clk;
    logic sync;
    logic sdata_out;
    logic sdata_in;

    modport master (input bit_clk, input sdata_in, output sync, output sdata_out);
    modport slave  (output bit_clk, output sdata_in, input sync, input sdata_out);
endinterface

// File: rtl/ac97_codec_regfile.sv
`timescale 1ns/1ps
// 64x16 codec register file, word-addressed by address[6:1]; a write to 0x00
// restores defaults and the vendor ID words are read-only.
module ac97_codec_regfile
    import ac97_pkg::*;
(
    input  logic        clk,
    input  logic        reset_b,
    input  logic        i_we,
    input  logic [6:0]  i_waddr,
    input  logic [15:0] i_wdata,
    input  logic [5:0]  i_ridx,
    output logic [15:0] o_rdata
);

    logic [15:0] r_mem [64];
    logic [6:0]  w_wword;

    assign w_wword = {i_waddr[6:1], 1'b0};

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            for (int i = 0; i < 64; i++) r_mem[i] <= reg_reset_value(6'(i));
        end else if (i_we) begin
            if (i_waddr == REG_RESET) begin
                for (int i = 0; i < 64; i++) r_mem[i] <= reg_reset_value(6'(i));
            end else if (w_wword != REG_VENDOR_ID1 && w_wword != REG_VENDOR_ID2) begin
                r_mem[i_waddr[6:1]] <= i_wdata;
            end
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/ac97_codec_slave.sv
`timescale 1ns/1ps
// AC97 codec link partner: bit_clk divider, deframer latching tag and slots 1-4,
// codec register file and a serializer returning read data on sdata_in.
module ac97_codec_slave
    import ac97_pkg::*;
#(
    parameter int READY_DELAY = 256
) (
    input  logic                clk,
    input  logic                reset_b,
    ac97_codec_slave_if.slave   link,
    output logic [TAG_W-1:0]    slot_0,
    output logic [SLOT_W-1:0]   slot_1,
    output logic [SLOT_W-1:0]   slot_2,
    output logic [SLOT_W-1:0]   slot_3,
    output logic [SLOT_W-1:0]   slot_4,
    output logic                frame_done,
    output deframe_state_t      o_dbg_state
);

    localparam int RDY_W = $clog2(READY_DELAY + 1);

    deframe_state_t        r_state;
    logic                  r_bit_clk, r_sdata_in, r_sync_prev, r_frame_done;
    logic                  r_ready, r_rd_pend;
    logic [7:0]            r_cnt;
    logic [RDY_W-1:0]      r_rdy_cnt;
    logic [DEFRAME_BITS-1:0] r_shift;
    logic [RESP_BITS-1:0]  r_tx_shift;
    logic [6:0]            r_rd_addr;
    logic [TAG_W-1:0]      r_slot_0;
    logic [SLOT_W-1:0]     r_slot_1, r_slot_2, r_slot_3, r_slot_4;

    logic                  w_fall, w_sync_rise, w_sample, w_last, w_cmd, w_we;
    logic [7:0]            w_idx;
    logic [15:0]           w_rd_data;
    logic [RESP_BITS-1:0]  w_tx_word;
    rx_frame_t             w_rx;

    // bit_clk high means this clk edge takes it 1->0: the controller's sample point.
    assign w_fall      = r_bit_clk;
    assign w_sync_rise = link.sync & ~r_sync_prev;
    assign w_sample    = w_sync_rise | (r_state == ST_RUN);
    assign w_idx       = w_sync_rise ? 8'd0 : r_cnt + 8'd1;
    assign w_last      = w_sample && (w_idx == 8'(FRAME_LEN - 1));
    assign w_rx        = rx_frame_t'(r_shift);
    assign w_cmd       = w_rx.tag[TAG_FRAME_VALID] & w_rx.tag[TAG_SLOT1_VALID];
    assign w_we        = w_fall & w_last & w_cmd & w_rx.tag[TAG_SLOT2_VALID] & ~w_rx.s1[19];

    assign w_tx_word = {r_ready, r_rd_pend, r_rd_pend, 13'h0000,
                        r_rd_pend ? {1'b0, r_rd_addr, 12'h000} : 20'h00000,
                        r_rd_pend ? {w_rd_data, 4'h0} : 20'h00000};

    ac97_codec_regfile u_regfile (
        .clk     (clk),
        .reset_b (reset_b),
        .i_we    (w_we),
        .i_waddr (w_rx.s1[18:12]),
        .i_wdata (w_rx.s2[19:4]),
        .i_ridx  (r_rd_addr[6:1]),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            r_state      <= ST_IDLE;
            r_bit_clk    <= 1'b0;
            r_sdata_in   <= 1'b0;
            // Starting high forces a genuine 0->1 sync edge after reset.
            r_sync_prev  <= 1'b1;
            r_frame_done <= 1'b0;
            r_ready      <= 1'b0;
            r_rd_pend    <= 1'b0;
            r_cnt        <= 8'd0;
            r_rdy_cnt    <= '0;
            r_shift      <= '0;
            r_tx_shift   <= '0;
            r_rd_addr    <= 7'd0;
            r_slot_0     <= '0;
            r_slot_1     <= '0;
            r_slot_2     <= '0;
            r_slot_3     <= '0;
            r_slot_4     <= '0;
        end else begin
            r_bit_clk    <= ~r_bit_clk;
            r_frame_done <= 1'b0;
            if (w_fall) begin
                r_sync_prev <= link.sync;
                if (!r_ready) begin
                    if (r_rdy_cnt == RDY_W'(READY_DELAY - 1)) r_ready <= 1'b1;
                    else r_rdy_cnt <= r_rdy_cnt + RDY_W'(1);
                end
                if (w_sample) begin
                    r_cnt   <= w_idx;
                    r_state <= w_last ? ST_END : ST_RUN;
                    if (w_idx < 8'(DEFRAME_BITS)) r_shift <= {r_shift[DEFRAME_BITS-2:0], link.sdata_out};
                end
                if (w_last) begin
                    r_frame_done <= 1'b1;
                    r_slot_0     <= w_rx.tag;
                    if (w_rx.tag[TAG_FRAME_VALID]) begin
                        if (w_rx.tag[TAG_SLOT1_VALID]) r_slot_1 <= w_rx.s1;
                        if (w_rx.tag[TAG_SLOT2_VALID]) r_slot_2 <= w_rx.s2;
                        if (w_rx.tag[TAG_SLOT3_VALID]) r_slot_3 <= w_rx.s3;
                        if (w_rx.tag[TAG_SLOT4_VALID]) r_slot_4 <= w_rx.s4;
                    end
                    if (w_cmd && w_rx.s1[19]) begin
                        r_rd_pend <= 1'b1;
                        r_rd_addr <= w_rx.s1[18:12];
                    end
                end
            end else begin
                // Frames are back to back, so the rise after bit 255 carries bit 0.
                case (r_state)
                    ST_RUN: begin
                        r_sdata_in <= r_tx_shift[RESP_BITS-1];
                        r_tx_shift <= {r_tx_shift[RESP_BITS-2:0], 1'b0};
                    end
                    ST_END: begin
                        r_sdata_in <= w_tx_word[RESP_BITS-1];
                        r_tx_shift <= {w_tx_word[RESP_BITS-2:0], 1'b0};
                        r_rd_pend  <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                    default: r_sdata_in <= 1'b0;
                endcase
            end
        end
    end

    assign link.bit_clk  = r_bit_clk;
    assign link.sdata_in = r_sdata_in;
    assign slot_0        = r_slot_0;
    assign slot_1        = r_slot_1;
    assign slot_2        = r_slot_2;
    assign slot_3        = r_slot_3;
    assign slot_4        = r_slot_4;
    assign frame_done    = r_frame_done;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ac97_codec_slave.sv
`timescale 1ns/1ps
// Bench for ac97_codec_slave: acts as the AC97 controller, sends frames and
// checks deframed slots, register reads and the sdata_in response frame.
module tb_ac97_codec_slave;
    import ac97_pkg::*;

    typedef struct {
        logic [15:0] tag;
        logic [19:0] s1, s2, s3, s4;
        logic [15:0] e0;
        logic [19:0] e1, e2, e3, e4;
        logic [55:0] erx;
    } vec_t;

    logic           clk = 1'b0;
    logic           reset_b = 1'b0;
    logic [15:0]    slot_0;
    logic [19:0]    slot_1, slot_2, slot_3, slot_4;
    logic           frame_done;
    deframe_state_t o_dbg_state;
    int             n_checks = 0;
    int             n_errors = 0;
    int             fd_count = 0;
    vec_t           vec [16];

    ac97_codec_slave_if link ();

    ac97_codec_slave #(.READY_DELAY(256)) dut (
        .clk         (clk),
        .reset_b     (reset_b),
        .link        (link),
        .slot_0      (slot_0),
        .slot_1      (slot_1),
        .slot_2      (slot_2),
        .slot_3      (slot_3),
        .slot_4      (slot_4),
        .frame_done  (frame_done),
        .o_dbg_state (o_dbg_state)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (frame_done) fd_count++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Controller side: drive bit k after bit_clk rises and capture the codec's bit k.
    task automatic drive_bits(input logic [255:0] f, input int nbits, output logic [55:0] rx);
        rx = '0;
        for (int k = 0; k < nbits; k++) begin
            @(posedge link.bit_clk);
            #1;
            link.sync      = (k < 16);
            link.sdata_out = f[255-k];
            if (k < 56) rx[55-k] = link.sdata_in;
        end
    endtask

    task automatic send_frame(input logic [15:0] tag, input logic [19:0] s1, input logic [19:0] s2,
                              input logic [19:0] s3, input logic [19:0] s4, output logic [55:0] rx);
        drive_bits({tag, s1, s2, s3, s4, 160'h0}, 256, rx);
        @(negedge link.bit_clk);
        #1;
    endtask

    initial begin
        #5_000_000;
        n_errors++;
        $display("FAIL watchdog: run did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "timeout");
    end

    initial begin
        logic [55:0] rx;
        logic [19:0] sv3, sv4;
        int          fd_before;

        vec[0]  = '{16'h8000, 20'h00000, 20'h00000, 20'd7, 20'd9, 16'h8000, 20'h00000, 20'h00000, 20'h00032, 20'hFFFCE, {16'h8000, 40'h0}};
        vec[1]  = '{16'hE000, 20'h18000, 20'h12340, 20'd7, 20'd9, 16'hE000, 20'h18000, 20'h12340, 20'h00032, 20'hFFFCE, {16'h8000, 40'h0}};
        vec[2]  = '{16'hC000, 20'h98000, 20'h00000, 20'd7, 20'd9, 16'hC000, 20'h98000, 20'h12340, 20'h00032, 20'hFFFCE, {16'h8000, 40'h0}};
        vec[3]  = '{16'h8000, 20'h00000, 20'h00000, 20'd7, 20'd9, 16'h8000, 20'h98000, 20'h12340, 20'h00032, 20'hFFFCE, {16'hE000, 20'h18000, 20'h12340}};
        vec[4]  = '{16'hC000, 20'hFC000, 20'h00000, 20'd7, 20'd9, 16'hC000, 20'hFC000, 20'h12340, 20'h00032, 20'hFFFCE, {16'h8000, 40'h0}};
        vec[5]  = '{16'hE000, 20'h7C000, 20'hFFFF0, 20'd7, 20'd9, 16'hE000, 20'h7C000, 20'hFFFF0, 20'h00032, 20'hFFFCE, {16'hE000, 20'h7C000, 20'h41440}};
        vec[6]  = '{16'hC000, 20'hFC000, 20'h00000, 20'd7, 20'd9, 16'hC000, 20'hFC000, 20'hFFFF0, 20'h00032, 20'hFFFCE, {16'h8000, 40'h0}};
        vec[7]  = '{16'hE000, 20'h00000, 20'h00000, 20'd7, 20'd9, 16'hE000, 20'h00000, 20'h00000, 20'h00032, 20'hFFFCE, {16'hE000, 20'h7C000, 20'h41440}};
        vec[8]  = '{16'hC000, 20'h98000, 20'h00000, 20'd7, 20'd9, 16'hC000, 20'h98000, 20'h00000, 20'h00032, 20'hFFFCE, {16'h8000, 40'h0}};
        vec[9]  = '{16'h8000, 20'h00000, 20'h00000, 20'd7, 20'd9, 16'h8000, 20'h98000, 20'h00000, 20'h00032, 20'hFFFCE, {16'hE000, 20'h18000, 20'h80000}};
        vec[10] = '{16'hC000, 20'h82000, 20'h00000, 20'd7, 20'd9, 16'hC000, 20'h82000, 20'h00000, 20'h00032, 20'hFFFCE, {16'h8000, 40'h0}};
        vec[11] = '{16'hC000, 20'h84000, 20'h00000, 20'd7, 20'd9, 16'hC000, 20'h84000, 20'h00000, 20'h00032, 20'hFFFCE, {16'hE000, 20'h02000, 20'h80000}};
        vec[12] = '{16'h8000, 20'h00000, 20'h00000, 20'd7, 20'd9, 16'h8000, 20'h84000, 20'h00000, 20'h00032, 20'hFFFCE, {16'hE000, 20'h04000, 20'h80000}};
        vec[13] = '{16'h8000, 20'h00000, 20'h00000, 20'd7, 20'd9, 16'h8000, 20'h84000, 20'h00000, 20'h00032, 20'hFFFCE, {16'h8000, 40'h0}};
        vec[14] = '{16'h9000, 20'h00000, 20'h00000, 20'h00011, 20'h00022, 16'h9000, 20'h84000, 20'h00000, 20'h00011, 20'hFFFCE, {16'h8000, 40'h0}};
        vec[15] = '{16'h1800, 20'h00000, 20'h00000, 20'd5, 20'd6, 16'h1800, 20'h84000, 20'h00000, 20'h00011, 20'hFFFCE, {16'h8000, 40'h0}};

        // Clock/reset: hold reset, check idle outputs, then bit_clk toggling.
        link.sync      = 1'b0;
        link.sdata_out = 1'b0;
        reset_b        = 1'b0;
        repeat (50) @(negedge clk);
        check("rst_bit_clk", 64'(link.bit_clk), 64'd0);
        check("rst_sdata_in", 64'(link.sdata_in), 64'd0);
        check("rst_slot_3", 64'(slot_3), 64'd0);
        check("rst_slot_0", 64'(slot_0), 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_state", 64'(o_dbg_state), 64'(ST_IDLE));
        reset_b = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bit_clk_toggle", 64'(link.bit_clk), 64'((i % 2) == 0));
        end

        // Codec-ready: nothing in the first frame, tag bit 15 once the delay has elapsed.
        send_frame(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0, rx);
        check("first_frame_rx", 64'(rx), 64'd0);
        check("first_frame_done", 64'(frame_done), 64'd1);
        send_frame(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0, rx);
        send_frame(16'h0000, 20'h0, 20'h0, 20'h0, 20'h0, rx);
        check("codec_ready_tag", 64'(rx[55:40]), 64'h8000);

        // PCM sweep -50..50 in slot 3, negated in slot 4.
        for (int v = -50; v <= 50; v++) begin
            sv3 = 20'(v);
            sv4 = 20'(-v);
            send_frame(16'h9800, 20'h0, 20'h0, sv3, sv4, rx);
            check("pcm_slot_3", 64'(slot_3), 64'(sv3));
            check("pcm_slot_4", 64'(slot_4), 64'(sv4));
        end
        for (int i = 0; i < 10; i++) begin
            send_frame(16'h9800, 20'h0, 20'h0, 20'h00032, 20'hFFFCE, rx);
            check("pcm_hold_50", 64'(slot_3), 64'h00032);
        end

        // Table: slot validity, register writes/reads and response frames.
        for (int i = 0; i < 16; i++) begin
            send_frame(vec[i].tag, vec[i].s1, vec[i].s2, vec[i].s3, vec[i].s4, rx);
            check("tbl_frame_done", 64'(frame_done), 64'd1);
            check("tbl_slot_0", 64'(slot_0), 64'(vec[i].e0));
            check("tbl_slot_1", 64'(slot_1), 64'(vec[i].e1));
            check("tbl_slot_2", 64'(slot_2), 64'(vec[i].e2));
            check("tbl_slot_3", 64'(slot_3), 64'(vec[i].e3));
            check("tbl_slot_4", 64'(slot_4), 64'(vec[i].e4));
            check("tbl_sdata_in", 64'(rx), 64'(vec[i].erx));
        end

        // Resync at bit 100: the truncated frame must not complete.
        fd_before = fd_count;
        drive_bits({16'h9800, 20'h0, 20'h0, 20'hBBBBB, 20'hCCCCC, 160'h0}, 100, rx);
        send_frame(16'h9800, 20'h0, 20'h0, 20'h00AAA, 20'h00555, rx);
        @(negedge clk);
        check("resync_done_count", 64'(fd_count - fd_before), 64'd1);
        check("resync_slot_0", 64'(slot_0), 64'h9800);
        check("resync_slot_3", 64'(slot_3), 64'h00AAA);
        check("resync_slot_4", 64'(slot_4), 64'h00555);

        // Reset mid-frame: immediate clear, then recovery on a fresh sync.
        drive_bits({16'h9800, 20'h0, 20'h0, 20'h00777, 20'h00888, 160'h0}, 50, rx);
        reset_b = 1'b0;
        #1;
        check("midrst_slot_0", 64'(slot_0), 64'd0);
        check("midrst_slot_1", 64'(slot_1), 64'd0);
        check("midrst_slot_3", 64'(slot_3), 64'd0);
        check("midrst_bit_clk", 64'(link.bit_clk), 64'd0);
        check("midrst_sdata_in", 64'(link.sdata_in), 64'd0);
        check("midrst_frame_done", 64'(frame_done), 64'd0);
        check("midrst_state", 64'(o_dbg_state), 64'(ST_IDLE));
        repeat (5) @(negedge clk);
        reset_b = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(16'h9800, 20'h0, 20'h0, 20'h00123, 20'h00456, rx);
        check("recover_frame_done", 64'(frame_done), 64'd1);
        check("recover_slot_0", 64'(slot_0), 64'h9800);
        check("recover_slot_3", 64'(slot_3), 64'h00123);
        check("recover_slot_4", 64'(slot_4), 64'h00456);
        check("recover_rx", 64'(rx), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
